// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port integer register file: ABI register
// indices and default geometry.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    localparam int ZERO = 0;
    localparam int RA   = 1;
    localparam int SP   = 2;
    localparam int GP   = 3;
    localparam int TP   = 4;
    localparam int T0   = 5;
    localparam int T1   = 6;
    localparam int T2   = 7;
    localparam int S0   = 8;
    localparam int S1   = 9;
    localparam int A0   = 10;
    localparam int A1   = 11;
    localparam int A2   = 12;
    localparam int A3   = 13;
    localparam int A4   = 14;
    localparam int A5   = 15;
    localparam int A6   = 16;
    localparam int A7   = 17;
    localparam int S2   = 18;
    localparam int S3   = 19;
    localparam int S4   = 20;
    localparam int S5   = 21;
    localparam int S6   = 22;
    localparam int S7   = 23;
    localparam int S8   = 24;
    localparam int S9   = 25;
    localparam int S10  = 26;
    localparam int S11  = 27;
    localparam int T3   = 28;
    localparam int T4   = 29;
    localparam int T5   = 30;
    localparam int T6   = 31;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: index mux, x0/bypass selection and an optional output
// register that captures on ren.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int NREGS     = DEF_NREGS,
    parameter int BYPASS    = 1,
    parameter int SYNC_READ = 0,
    parameter int AW        = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  regs [NREGS],
    input  logic [NREGS-1:0] sb,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [XLEN-1:0]  rdata,
    output logic             rbusy
);

    logic [XLEN-1:0] w_data;
    logic            w_busy;

    // A write still in flight when reset hits is discarded, so it must not forward either.
    always_comb begin
        w_data = '0;
        w_busy = 1'b0;
        if (raddr != AW'(ZERO)) begin
            if ((BYPASS != 0) && we && !rst && (waddr == raddr)) begin
                w_data = wdata;
                w_busy = 1'b0;
            end else begin
                w_data = regs[raddr];
                w_busy = sb[raddr];
            end
        end
    end

    generate
        if (SYNC_READ != 0) begin : g_sync
            logic [XLEN-1:0] r_data;
            logic            r_busy;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data <= '0;
                    r_busy <= 1'b0;
                end else if (ren) begin
                    r_data <= w_data;
                    r_busy <= w_busy;
                end
            end

            assign rdata = r_data;
            assign rbusy = r_busy;
        end else begin : g_comb
            logic w_unused;
            assign w_unused = ren ^ clk;
            assign rdata    = w_data;
            assign rbusy    = w_busy;
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with one write port, NREAD read ports and
// a pending-write scoreboard; x0 is hardwired to zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int NREGS     = DEF_NREGS,
    parameter int NREAD     = 2,
    parameter int BYPASS    = 1,
    parameter int SYNC_READ = 0,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  busy_set,
    input  logic [AW-1:0]         busy_addr,
    input  logic [NREAD-1:0]      ren,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_sb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (we && (waddr != AW'(ZERO))) begin
            r_regs[waddr] <= wdata;
        end
    end

    // A new issue to the same register outranks the retiring write: set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (busy_set && (busy_addr == AW'(i))) r_sb[i] <= 1'b1;
                else if (we && (waddr == AW'(i)))     r_sb[i] <= 1'b0;
            end
        end
    end

    generate
        for (genvar p = 0; p < NREAD; p++) begin : g_rd
            regfile_read_port #(
                .XLEN      (XLEN),
                .NREGS     (NREGS),
                .BYPASS    (BYPASS),
                .SYNC_READ (SYNC_READ),
                .AW        (AW)
            ) u_port (
                .clk   (clk),
                .rst   (rst),
                .regs  (r_regs),
                .sb    (r_sb),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .ren   (ren[p]),
                .raddr (raddr[p*AW +: AW]),
                .rdata (rdata[p*XLEN +: XLEN]),
                .rbusy (rbusy[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass, no-bypass, registered-read and a
// 3-port 64-bit instance driven from one shared stimulus sequence.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy_set;
    logic [4:0]  busy_addr;
    logic [1:0]  ren;
    logic [9:0]  raddr;

    logic [63:0]  rd0, rd1, rd2;
    logic [1:0]   rb0, rb1, rb2;
    logic [63:0]  wdata3;
    logic [2:0]   ren3;
    logic [14:0]  raddr3;
    logic [191:0] rd3;
    logic [2:0]   rb3;

    int n_tests = 0;
    int n_fail  = 0;

    assign wdata3 = {~wdata, wdata};
    assign ren3   = {ren[0], ren};
    assign raddr3 = {raddr[4:0], raddr};

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .SYNC_READ(0)) u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .busy_set(busy_set), .busy_addr(busy_addr), .ren(ren), .raddr(raddr),
        .rdata(rd0), .rbusy(rb0));

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0), .SYNC_READ(0)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .busy_set(busy_set), .busy_addr(busy_addr), .ren(ren), .raddr(raddr),
        .rdata(rd1), .rbusy(rb1));

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .SYNC_READ(1)) u2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .busy_set(busy_set), .busy_addr(busy_addr), .ren(ren), .raddr(raddr),
        .rdata(rd2), .rbusy(rb2));

    regfile_mp #(.XLEN(64), .NREGS(32), .NREAD(3), .BYPASS(1), .SYNC_READ(0)) u3 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata3),
        .busy_set(busy_set), .busy_addr(busy_addr), .ren(ren3), .raddr(raddr3),
        .rdata(rd3), .rbusy(rb3));

    always #5 clk = ~clk;

    function automatic logic [63:0] ext(input logic [31:0] e);
        return (e == 32'd0) ? 64'd0 : {~e, e};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stable-cycle read check across both combinational 32-bit instances and the 64-bit one.
    task automatic chk_read(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic b0, input logic b1);
        chk({tag, "_u0d"}, rd0, {e1, e0});
        chk({tag, "_u0b"}, {62'd0, rb0}, {62'd0, b1, b0});
        chk({tag, "_u1d"}, rd1, {e1, e0});
        chk({tag, "_u1b"}, {62'd0, rb1}, {62'd0, b1, b0});
        chk({tag, "_u3p0"}, rd3[63:0], ext(e0));
        chk({tag, "_u3p1"}, rd3[127:64], ext(e1));
        chk({tag, "_u3p2"}, rd3[191:128], ext(e0));
        chk({tag, "_u3b"}, {61'd0, rb3}, {61'd0, b0, b1, b0});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        busy_set = 1'b0; busy_addr = '0; ren = '0; raddr = '0;
        #1;
        chk("rst_sync_rd", rd2, 64'd0);
        #12 rst = 1'b0;
        step();

        // 1. all indices read zero and not busy after reset
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(i), 5'(31 - i)};
            #1;
            chk_read("t1", 32'd0, 32'd0, 1'b0, 1'b0);
        end

        // 2. write x5, then attempt a write to x0
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
        step();
        we = 1'b0;
        #1;
        chk_read("t2_x5", 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr = {5'd5, 5'd0};
        #1;
        chk("t2_x0_nobyp", rd0[31:0], 64'd0);
        step();
        we = 1'b0;
        #1;
        chk_read("t2_x0", 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);

        // 3. same-cycle write/read of x7: bypass vs. no bypass
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        step();
        wdata = 32'hA5A5A5A5; raddr = {5'd0, 5'd7};
        #1;
        chk("t3_byp_u0", rd0[31:0], 64'hA5A5A5A5);
        chk("t3_old_u1", rd1[31:0], 64'h11111111);
        chk("t3_byp_u3", rd3[63:0], ext(32'hA5A5A5A5));
        step();
        we = 1'b0;
        #1;
        chk_read("t3_after", 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);

        // 4. scoreboard set, set-wins, clear, x0 ignored
        busy_set = 1'b1; busy_addr = 5'd10; raddr = {5'd10, 5'd7};
        #1;
        chk("t4_set_lat", {63'd0, rb0[1]}, 64'd0);
        step();
        busy_set = 1'b0;
        #1;
        chk_read("t4_busy", 32'hA5A5A5A5, 32'd0, 1'b0, 1'b1);
        we = 1'b1; waddr = 5'd10; wdata = 32'h0000BEEF; busy_set = 1'b1; busy_addr = 5'd10;
        #1;
        chk("t4_byp_busy_u0", {63'd0, rb0[1]}, 64'd0);
        chk("t4_byp_data_u0", rd0[63:32], 64'h0000BEEF);
        chk("t4_nobyp_busy_u1", {63'd0, rb1[1]}, 64'd1);
        step();
        we = 1'b0; busy_set = 1'b0;
        #1;
        chk_read("t4_setwins", 32'hA5A5A5A5, 32'h0000BEEF, 1'b0, 1'b1);
        we = 1'b1; waddr = 5'd10; wdata = 32'h0000CAFE;
        step();
        we = 1'b0;
        #1;
        chk_read("t4_clear", 32'hA5A5A5A5, 32'h0000CAFE, 1'b0, 1'b0);
        busy_set = 1'b1; busy_addr = 5'd0; raddr = {5'd0, 5'd7};
        step();
        busy_set = 1'b0;
        #1;
        chk_read("t4_x0busy", 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);

        // 5. registered read: capture on ren, hold otherwise
        we = 1'b1; waddr = 5'd3; wdata = 32'h00000055;
        step();
        we = 1'b0; ren = 2'b01; raddr = {5'd0, 5'd3};
        #1;
        chk("t5_before", rd2[31:0], 64'd0);
        step();
        ren = 2'b00; raddr = {5'd0, 5'd5};
        #1;
        chk("t5_capture", rd2[31:0], 64'h55);
        chk("t5_p1_held", rd2[63:32], 64'd0);
        step();
        chk("t5_hold", rd2[31:0], 64'h55);
        chk("t5_comb_x5", rd0[31:0], 64'hDEADBEEF);
        busy_set = 1'b1; busy_addr = 5'd3;
        step();
        busy_set = 1'b0; ren = 2'b01; raddr = {5'd0, 5'd3};
        step();
        ren = 2'b00;
        #1;
        chk("t5_busy_cap", {63'd0, rb2[0]}, 64'd1);
        chk("t5_data_cap", rd2[31:0], 64'h55);

        // 6. asynchronous reset mid-cycle with a write in flight
        we = 1'b1; waddr = 5'd20; wdata = 32'hCAFEF00D;
        step();
        busy_set = 1'b1; busy_addr = 5'd12; wdata = 32'hFFFFFFFF;
        raddr = {5'd12, 5'd20}; ren = 2'b11;
        #2 rst = 1'b1;
        #1;
        chk("t6_u0d", rd0, 64'd0);
        chk("t6_u0b", {62'd0, rb0}, 64'd0);
        chk("t6_u1d", rd1, 64'd0);
        chk("t6_u1b", {62'd0, rb1}, 64'd0);
        chk("t6_u2d", rd2, 64'd0);
        chk("t6_u2b", {62'd0, rb2}, 64'd0);
        chk("t6_u3lo", rd3[127:0] == 128'd0 ? 64'd0 : 64'd1, 64'd0);
        chk("t6_u3hi", rd3[191:128], 64'd0);
        chk("t6_u3b", {61'd0, rb3}, 64'd0);
        we = 1'b0; busy_set = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk_read("t6_after", 32'd0, 32'd0, 1'b0, 1'b0);
        raddr = {5'd3, 5'd5};
        #1;
        chk_read("t6_x5x3", 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("t6_sync_after", rd2, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
